// File: rtl/imc_pkg.sv
// Shared constants and types for the bit-serial in-memory-compute MAC datapath.
package imc_pkg;
    localparam int N_LANE = 16;
    localparam int N_BANK = 4;
    localparam int W_BITS = 4;
    localparam int SUM_W  = W_BITS + $clog2(N_LANE);
    localparam int ABITS  = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = $clog2(ABITS + 1);

    typedef logic [W_BITS-1:0] pp_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;
endpackage

// File: rtl/lane_adder_tree.sv
// Combinational reduction of one bank's lane partial products to an unsigned plane sum.
module lane_adder_tree
    import imc_pkg::*;
(
    input  pp_t [N_LANE-1:0] i_pp,
    output sum_t             o_sum
);

    // Two-level reduction: pairs first, then the pair sums.
    sum_t [N_LANE/2-1:0] w_pair;

    always_comb begin
        for (int i = 0; i < N_LANE/2; i++) begin
            w_pair[i] = sum_t'(i_pp[2*i]) + sum_t'(i_pp[2*i+1]);
        end
        o_sum = '0;
        for (int i = 0; i < N_LANE/2; i++) begin
            o_sum = o_sum + w_pair[i];
        end
    end

endmodule

// File: rtl/bitserial_shift_accumulator.sv
// Reduces per-bank partial products each bit-plane and shift-accumulates ABITS planes
// (MSB first) into one dot product per weight bank.
module bitserial_shift_accumulator
    import imc_pkg::*;
#(
    parameter int SIGNED_ACT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  pp_t  [N_BANK*N_LANE-1:0]        mul_result,
    output acc_t [N_BANK-1:0]               acc_out,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            err_restart
);

    // MSB plane carries negative weight for two's-complement activations.
    function automatic acc_t plane_term(input sum_t s, input logic neg);
        acc_t z;
        z = acc_t'(s);
        return neg ? -z : z;
    endfunction

    sum_t [N_BANK-1:0] w_sum;

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        lane_adder_tree u_tree (
            .i_pp  (mul_result[b*N_LANE +: N_LANE]),
            .o_sum (w_sum[b])
        );
    end

    // ---- S1: registered plane sums ----
    sum_t [N_BANK-1:0] r_sum_p1;
    logic              r_vld_p1;
    logic              r_first_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
        end else begin
            r_vld_p1   <= in_valid;
            r_first_p1 <= in_first;
        end
    end

    always_ff @(posedge clk) begin
        r_sum_p1 <= w_sum;
    end

    // ---- S2: shift-accumulate, plane counter, word FSM ----
    acc_state_t        r_state;
    acc_state_t        w_state_nxt;
    cnt_t              r_cnt;
    cnt_t              w_cnt_nxt;
    acc_t [N_BANK-1:0] r_acc_p2;
    acc_t [N_BANK-1:0] w_acc_nxt;
    logic              w_done;
    logic              w_restart;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc_p2;
        w_done      = 1'b0;
        w_restart   = 1'b0;
        if (r_vld_p1) begin
            if (r_first_p1) begin
                w_restart   = (r_state == ST_ACCUM);
                w_state_nxt = ST_ACCUM;
                w_cnt_nxt   = cnt_t'(1);
                for (int b = 0; b < N_BANK; b++) begin
                    w_acc_nxt[b] = plane_term(r_sum_p1[b], SIGNED_ACT != 0);
                end
            end else if (r_state == ST_ACCUM) begin
                w_cnt_nxt = r_cnt + cnt_t'(1);
                for (int b = 0; b < N_BANK; b++) begin
                    w_acc_nxt[b] = (r_acc_p2[b] << 1) + acc_t'(r_sum_p1[b]);
                end
            end
            // A stray non-first plane while idle leaves everything untouched.
            if (w_state_nxt == ST_ACCUM && w_cnt_nxt == cnt_t'(ABITS)) begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            acc_out     <= '0;
            out_valid   <= 1'b0;
            err_restart <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            out_valid   <= w_done;
            err_restart <= w_restart;
            if (w_done) begin
                acc_out <= w_acc_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_acc_p2 <= w_acc_nxt;
    end

    assign busy = (r_state == ST_ACCUM);

endmodule
